// File: rtl/clock_gate_ctrl_if.sv
// Activity handshake between upstream logic and the clock-gate controller.
// Upstream drives requests and overrides; the controller answers with ready.
interface clock_gate_ctrl_if;
  logic act_req;
  logic act_ready;
  logic domain_busy;
  logic force_on;

  modport master (
    output act_req,
    output domain_busy,
    output force_on,
    input  act_ready
  );

  modport slave (
    input  act_req,
    input  domain_busy,
    input  force_on,
    output act_ready
  );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Enable-side controller for a gated clock domain: idle gate-off,
// fixed wake latency before ready, saturating gated-cycle counter.
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_gate_ctrl_if.slave act,
  input  logic             cnt_clr,
  output logic             gate_en,
  output logic [CNT_W-1:0] gated_cnt
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  localparam logic [IW-1:0] IDLE_LAST =
    IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST =
    WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAKE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_d;
  logic [WW-1:0] wake_cnt;
  logic [WW-1:0] wake_d;
  logic          idle;
  logic          cnt_sat;

  assign idle = !act.act_req
             && !act.domain_busy
             && !act.force_on;

  assign cnt_sat = &gated_cnt;

  // Enables decode registered state only, so no input can glitch them.
  assign gate_en       = (state_q != ST_OFF);
  assign act.act_ready = (state_q == ST_ON);

  // State and counter registers; reset lands in WAKE with clock running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAKE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      state_q  <= state_d;
      idle_cnt <= idle_d;
      wake_cnt <= wake_d;
    end
  end

  // Next-state logic: WAKE runs to completion, ON counts idle, OFF waits.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_cnt;
    wake_d  = wake_cnt;
    unique case (state_q)
      ST_WAKE: begin
        wake_d = wake_cnt + 1'b1;
        if (wake_cnt == WAKE_LAST) begin
          state_d = ST_ON;
          idle_d  = '0;
        end
      end
      ST_ON: begin
        if (!idle) begin
          idle_d = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_d = ST_OFF;
        end else begin
          idle_d = idle_cnt + 1'b1;
        end
      end
      ST_OFF: begin
        if (!idle) begin
          state_d = ST_WAKE;
          wake_d  = '0;
        end
      end
      default: begin
        state_d = ST_WAKE;
        wake_d  = '0;
      end
    endcase
  end

  // Gated-cycle counter; clear beats increment, holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_cnt <= '0;
    end else if (cnt_clr) begin
      gated_cnt <= '0;
    end else if (state_q == ST_OFF && !cnt_sat) begin
      gated_cnt <= gated_cnt + 1'b1;
    end
  end

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Enable-side controller for a gated clock domain in the accelerator. It produces the registered `gate_en` that drives the domain's integrated clock-gating cell. It turns the domain clock off after a programmable run of idle cycles and restores it on demand. A valid/ready-style handshake tells upstream logic when the gated domain is clocked and stable enough to accept work. It also keeps a saturating count of gated-off cycles for power monitoring.

## Interface
Parameters:
- `IDLE_CYCLES`, default 16: consecutive idle cycles in ON before gating off. Must be ≥1.
- `WAKE_CYCLES`, default 2: cycles the clock runs after ungating before `act_ready` rises. Must be ≥1.
- `CNT_W`, default 32: width of `gated_cnt`.

Ports:
- `clk`  in  1  free-running ungated clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `act_req`  in  1  upstream has work for the domain (level; held until accepted).
- `act_ready`  out  1  domain clocked and settled; transfer occurs when `act_req && act_ready`.
- `domain_busy`  in  1  gated domain still has work in flight.
- `force_on`  in  1  DFT/software override; keeps or brings the clock on.
- `cnt_clr`  in  1  synchronous clear of `gated_cnt`.
- `gate_en`  out  1  enable to the clock-gating cell.
- `gated_cnt`  out  CNT_W  saturating count of cycles spent in OFF.

## Operation
- **Idle cycle:** `act_req`=0, `domain_busy`=0 and `force_on`=0, all sampled at the rising edge of `clk`.
- **States:** WAKE, ON and OFF. Counters:
  - `idle_cnt`, width $clog2(IDLE_CYCLES+1).
  - `wake_cnt`, width $clog2(WAKE_CYCLES+1).
- **Reset (async, `rst_n`=0):**
  - state=WAKE, `wake_cnt`=0, `idle_cnt`=0.
  - Outputs: `gate_en`=1, `act_ready`=0, `gated_cnt`=0.
  - The domain is clocked throughout and after reset so its own flops initialise.
- **WAKE:**
  - `gate_en`=1, `act_ready`=0.
  - `wake_cnt` increments each cycle.
  - When `wake_cnt`==WAKE_CYCLES-1, next state is ON and `idle_cnt` is cleared.
  - Dropping requests during WAKE does not abort it; WAKE always completes.
- **ON:**
  - `gate_en`=1, `act_ready`=1.
  - A non-idle cycle clears `idle_cnt`.
  - On an idle cycle with `idle_cnt`==IDLE_CYCLES-1, next state is OFF. Otherwise an idle cycle increments `idle_cnt`.
- **OFF:**
  - `gate_en`=0, `act_ready`=0.
  - Any non-idle cycle moves to WAKE with `wake_cnt`=0.
  - `force_on` follows the same path and does not bypass the wake latency.
- **gated_cnt:**
  - +1 for every edge at which state was OFF, including the OFF→WAKE exit cycle.
  - Saturates at all-ones.
  - `cnt_clr` loads 0 and wins over a simultaneous increment.
- **Glitch-free enable:**
  - `gate_en` is a flop output or a decode of registered state only.
  - No combinational path from any input to `gate_en` or `act_ready`.
- **Upstream rule:** once asserted, `act_req` stays high until a transfer. The block does not check this.

## Timing
- **Gate-off:** after IDLE_CYCLES consecutive idle cycles in ON, `gate_en` falls at the edge ending the last idle cycle.
- **Wake latency:** request sampled in OFF at edge t gives:
  - `gate_en`=1 from t+1;
  - `act_ready`=1 from t+1+WAKE_CYCLES.
- **Activity during idle count:** a non-idle cycle at any `idle_cnt` value restarts the full IDLE_CYCLES count.
- **Simultaneous events:**
  - Idle-threshold edge with `force_on` or `act_req` high: not idle, so the state stays ON.
  - `cnt_clr` with saturation or increment: result is 0.
- **Reset mid-operation (any state):** `gate_en` returns to 1 immediately and asynchronously, and `act_ready` goes to 0.
- **After `rst_n` deassertion:** `act_ready` rises after WAKE_CYCLES edges.

## Test plan
- **Reset:** hold `rst_n`=0, then release with WAKE_CYCLES=2 → `gate_en`=1, `act_ready`=0 and `gated_cnt`=0 during reset; `act_ready`=1 after 2 edges.
- **Idle gate-off:** IDLE_CYCLES=16, all inputs low from ON entry → `gate_en` falls after the 16th idle edge; `gated_cnt` then counts 1, 2, 3, …
- **Restart of idle count:** pulse `domain_busy` for 1 cycle when `idle_cnt`=15 → stays ON; gate-off occurs only after 16 further idle cycles.
- **Wake handshake:** in OFF, raise and hold `act_req` at edge t → `gate_en`=1 at t+1, `act_ready`=1 at t+3, transfer at t+3. `gated_cnt` equals the OFF cycle count including edge t.
- **force_on and counter:**
  - `force_on`=1 in OFF → WAKE then ON, no gate-off while held.
  - CNT_W=4, stay in OFF more than 20 cycles → `gated_cnt` holds at 15.
  - `cnt_clr` on the same cycle as an increment → `gated_cnt`=0.
- **Async reset while gated:** assert `rst_n`=0 mid-OFF between clock edges → `gate_en`=1 immediately, then a normal WAKE sequence follows.
